// File: rtl/uart_word_tx.sv
// Word-to-byte serializer for the UART transmitter: buffers 32-bit words in a FIFO
// and sends each one MSB-first as four bytes through the uart wr/busy handshake.
module uart_word_tx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     axis_tvalid_i,
  output logic                     axis_tready_o,
  input  logic [31:0]              axis_tdata_i,
  output logic                     uart_wr_o,
  output logic [7:0]               uart_tx_data_o,
  input  logic                     uart_busy_i,
  output logic                     idle_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   shift_q;
  logic [1:0]    idx_q;
  logic          full, empty, push;
  logic          pop, strobe, shift_en, idx_clr, idx_inc;

  assign full          = (level_o == LW'(DEPTH));
  assign empty         = (level_o == '0);
  assign axis_tready_o = !full && !reset_i;
  assign push          = axis_tvalid_i && axis_tready_o;
  assign idle_o        = empty && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and control decode; GUARD ignores busy while the UART picks up the strobe
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    strobe   = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          idx_clr = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!uart_busy_i) begin
          strobe  = 1'b1;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        shift_en = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (!uart_busy_i) begin
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy and pointers do
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axis_tdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      shift_q        <= '0;
      idx_q          <= '0;
      uart_wr_o      <= 1'b0;
      uart_tx_data_o <= 8'h00;
    end else begin
      uart_wr_o <= strobe;
      if (strobe) uart_tx_data_o <= shift_q[31:24];
      if (pop) begin
        shift_q <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end else if (shift_en) begin
        shift_q <= {shift_q[23:0], 8'h00};
      end
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + 2'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
    end
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side companion to the UART command receiver. It accepts 32-bit words on an AXI-stream-style slave port, buffers them in a small FIFO, and serializes each word MSB-first as four bytes into the `uart` transmitter through its `wr_i`/`busy_o` handshake. The byte order matches the receive-side assembler, so a word sent by this block is reassembled into the identical word at the far end. It sits between a word producer (status/readback or loopback path) and the `uart` `tx_data_i`/`wr_i`/`busy_o` pins, in the `clk_pix` domain.

## Interface
- `DEPTH`, 4, FIFO depth in 32-bit words; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `axis_tvalid_i`  in  1  producer has a word.
- `axis_tready_o`  out  1  block can accept a word; equals `!full && !reset_i` (combinational).
- `axis_tdata_i`  in  32  word to send.
- `uart_wr_o`  out  1  registered one-cycle write strobe to `uart.wr_i`.
- `uart_tx_data_o`  out  8  registered byte to `uart.tx_data_i`; held stable from the strobe until the next strobe.
- `uart_busy_i`  in  1  `uart.busy_o`. It must rise no later than one cycle after the UART samples `uart_wr_o` high.
- `idle_o`  out  1  FIFO empty and FSM in IDLE.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- **Push:** `axis_tvalid_i && axis_tready_o` at an edge writes `axis_tdata_i` into the FIFO; `level_o` increments.
- **Pop:** occurs in IDLE with FIFO not empty.
  - The head word is loaded into a 32-bit shift register.
  - The byte index is cleared to 0 and the FSM moves to SEND.
  - `level_o` decrements.
- **Simultaneous push and pop:** `level_o` is unchanged and both take effect. When full, `axis_tready_o` is 0, so no push occurs even if a pop happens in that cycle.
- **FSM states:**
  - IDLE: pop as described above.
  - SEND: if `!uart_busy_i`, then `uart_wr_o<=1`, `uart_tx_data_o<=shift[31:24]`, go to GUARD. Otherwise stay in SEND.
  - GUARD: `uart_wr_o<=0` and shift left by 8. `uart_busy_i` is ignored in this state. Go to WAIT.
  - WAIT: if `!uart_busy_i` and index==3, go to IDLE. If `!uart_busy_i` and index<3, increment the index and go to SEND. Otherwise stay in WAIT.
- **Byte order:** bits [31:24], [23:16], [15:8], [7:0].
- **Flow control:** the producer may stall indefinitely. `axis_tdata_i` is sampled only on a handshake.
- **Reset:** aborts any word in progress, including mid-word. The partial word is not resumed, and the FIFO contents are discarded.

## Timing
- **Reset values:**
  - `uart_wr_o=0`, `uart_tx_data_o=8'h00`, `level_o=0`, FSM=IDLE, index=0.
  - `idle_o=1` one cycle after reset.
  - `axis_tready_o=0` while `reset_i` is high, and 1 in the first cycle after it drops.
- **Latency** (empty FIFO, IDLE, `uart_busy_i`=0): handshake at edge E0, pop at E1, `uart_wr_o` high during the cycle after E2 (two cycles after the push edge).
- **Strobe width:** `uart_wr_o` is high for exactly one cycle per byte and is never high in consecutive cycles.
- **Per-byte overhead:** minimum gap between strobes is the UART busy time plus 2 cycles (GUARD, then WAIT→SEND).
- **Word boundary:** one extra IDLE cycle between words (WAIT→IDLE→pop→SEND).
- **Throughput:** with UART busy time B, throughput is one word per 4·(B+3)+1 cycles.
- **Back-pressure:** `axis_tready_o` deasserts in the cycle after the push that makes `level_o`=DEPTH. It reasserts in the cycle after a pop.

## Test plan
1. **Single word:** reset, then push 0xA1B2C3D4 with the UART model holding busy 10 cycles after each strobe. Required: exactly 4 strobes with bytes A1, B2, C3, D4; `idle_o` returns to 1; `level_o` ends at 0.
2. **Latency:** push a word while `uart_busy_i`=0 is tied low. Required: the first `uart_wr_o` pulse occurs two cycles after the push edge, and strobes are never adjacent.
3. **Backlog fill** (DEPTH=4, UART busy 50 cycles):
   - Hold `tvalid` and push 0x00000001..0x00000006.
   - Required: five words are accepted before `tready` first drops (four stored plus one popped).
   - Required: `level_o` reaches 4; `tready` reasserts one cycle after the next pop.
   - Required: 24 bytes appear in order with no loss or duplication.
4. **Full-boundary push/pop:** hold `tvalid` while full and time a pop. Required: the push is accepted only in the cycle after the pop and `level_o` never exceeds 4.
5. **Reset mid-word:** assert `reset_i` after byte 2 of 0xDEADBEEF with 2 words queued. Required: no further strobes, `level_o=0`, `idle_o=1`. A new word 0x11223344 sent afterwards yields 11, 22, 33, 44.
6. **Loopback:** connect to `uart` and the receive-side assembler and send random words. Required: each word is reproduced bit-exact on the graphite command stream.
